instr_sequencer: RTL and testbench

Multi-cycle fetch/issue controller that drives the RV32I register-write datapath (`top_level`) from a synchronous instruction ROM. It replaces hand-fed instruction and write-enable stimulus with a program counter and a 3-cycle-per-instruction state machine. It supports run-to-halt and single-step modes, abort, and instruction counting. It sits between the instruction memory and `top_level`, driving `top_level`'s instruction and write-enable inputs directly.

---
 rtl/instr_sequencer_pkg.sv | 22 ++
 rtl/instr_sequencer_if.sv | 11 +
 rtl/instr_sequencer_classifier.sv | 25 ++
 rtl/instr_sequencer.sv | 107 ++++++++++
 tb/tb_instr_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer and its opcode classifier.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_PAUSE,
    S_HALTED
  } seq_state_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [31:0] HALT_INSTR = 32'h0000_0073;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction ROM bus: sequencer drives enable/address, ROM returns data one cycle later.
interface instr_sequencer_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  imem_en_o;
  logic [ADDR_WIDTH-1:0] imem_addr_o;
  logic [31:0]           imem_data_i;

  modport master (output imem_en_o, output imem_addr_o, input imem_data_i);
  modport slave  (input imem_en_o, input imem_addr_o, output imem_data_i);
endinterface

// File: rtl/instr_sequencer_classifier.sv
// Combinational RV32I opcode classifier: legality, rd-write (rd != x0) and halt detection.
module instr_classifier
  import seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic        legal,
  output logic        writes_rd,
  output logic        is_halt
);

  always_comb begin
    legal     = 1'b0;
    writes_rd = 1'b0;
    is_halt   = (instr == HALT_INSTR);
    case (instr[6:0])
      OP, OP_IMM, LUI, AUIPC: begin
        legal     = 1'b1;
        writes_rd = (instr[11:7] != 5'd0);
      end
      STORE, BRANCH: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/load/issue controller feeding the register-write datapath from a synchronous ROM.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int RESET_PC   = 0
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  instr_sequencer_if.master     imem,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  step_mode_i,
  input  logic                  step_i,
  output logic [31:0]           instruction_o,
  output logic                  write_ena_o,
  output logic                  busy_o,
  output logic                  halted_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [15:0]           instr_count_o
);

  localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [15:0]           count_q;
  logic [31:0]           instr_q;
  logic                  err_q;
  logic                  wr_q;
  logic                  cls_legal, cls_writes_rd, cls_is_halt;

  instr_classifier u_classifier (
    .instr     (imem.imem_data_i),
    .legal     (cls_legal),
    .writes_rd (cls_writes_rd),
    .is_halt   (cls_is_halt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: if (start_i) state_d = S_FETCH;
      S_FETCH:          state_d = S_LOAD;
      S_LOAD: begin
        if (cls_is_halt || !cls_legal) state_d = S_HALTED;
        else                           state_d = S_ISSUE;
      end
      S_ISSUE:          state_d = step_mode_i ? S_PAUSE : S_FETCH;
      S_PAUSE:          if (step_i || !step_mode_i) state_d = S_FETCH;
      default:          state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  // Abort freezes PC, count, instruction and error; only the state returns to IDLE.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      pc_q    <= PC_INIT;
      count_q <= 16'd0;
      instr_q <= 32'd0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!abort_i) begin
        case (state_q)
          S_IDLE, S_HALTED: if (start_i) begin
            pc_q    <= PC_INIT;
            count_q <= 16'd0;
            err_q   <= 1'b0;
          end
          S_LOAD: begin
            instr_q <= imem.imem_data_i;
            wr_q    <= cls_writes_rd;
            if (!cls_is_halt && !cls_legal) err_q <= 1'b1;
          end
          S_ISSUE: begin
            count_q <= sat_inc(count_q);
            pc_q    <= pc_q + PC_STEP;
          end
          default: ;
        endcase
      end
    end
  end

  // Write strobe comes from the classification registered in LOAD, never from ROM data directly.
  assign write_ena_o      = (state_q == S_ISSUE) && wr_q && !abort_i;
  assign imem.imem_en_o   = (state_q == S_FETCH);
  assign imem.imem_addr_o = pc_q;
  assign busy_o           = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                            (state_q == S_ISSUE) || (state_q == S_PAUSE);
  assign halted_o         = (state_q == S_HALTED);
  assign error_o          = err_q;
  assign pc_o             = pc_q;
  assign instr_count_o    = count_q;
  assign instruction_o    = instr_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: single-instruction vector table plus multi-cycle sequences.
module tb_instr_sequencer;
  localparam int AW = 10;
  localparam logic [31:0] HALT = 32'h0000_0073;

  logic clk = 1'b0;
  logic rst;
  logic start, abort, step_mode, step;
  logic [31:0] instruction;
  logic we, busy, halted, err;
  logic [AW-1:0] pc;
  logic [15:0] cnt;

  instr_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  instr_sequencer #(.ADDR_WIDTH(AW), .RESET_PC(0)) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .imem          (bus.master),
    .start_i       (start),
    .abort_i       (abort),
    .step_mode_i   (step_mode),
    .step_i        (step),
    .instruction_o (instruction),
    .write_ena_o   (we),
    .busy_o        (busy),
    .halted_o      (halted),
    .error_o       (err),
    .pc_o          (pc),
    .instr_count_o (cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [0:15];
  logic [31:0] rom_q;
  always @(posedge clk) if (bus.imem_en_o) rom_q <= rom[bus.imem_addr_o[5:2]];
  assign bus.imem_data_i = rom_q;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_main_rom();
    for (int i = 0; i < 16; i++) rom[i] = HALT;
    rom[0] = 32'h0010_8093;
    rom[1] = 32'h0010_8133;
    rom[2] = 32'h0011_01B3;
    rom[3] = HALT;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int writes, output bit ok);
    writes = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (we) writes++;
      if (halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    int          writes;
    logic [15:0] count;
    logic        error;
    logic [AW-1:0] pc;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int writes;
    bit ok;
    logic [15:0] wv;
    int hold;

    rst = 1'b1; start = 0; abort = 0; step_mode = 0; step = 0;
    load_main_rom();
    #12;
    check("reset_pc", pc, 0);
    check("reset_instr", instruction, 0);
    check("reset_outs", {we, bus.imem_en_o, busy, halted, err}, 0);
    check("reset_count", cnt, 0);
    check("reset_addr", bus.imem_addr_o, 0);
    tick();
    rst = 1'b0;
    tick();

    // Main program: writes at edges 3/6/9; halt word fetched at edge 10, latched at 11, HALTED after 12.
    wv = '0;
    pulse_start();
    wv[1] = we;
    for (int k = 2; k <= 12; k++) begin
      tick();
      wv[k] = we;
      if (k == 3) check("issue1_instr", instruction, 32'h0010_8093);
      if (k == 9) check("issue3_instr", instruction, 32'h0011_01B3);
      if (k == 11) check("busy_before_halt", busy, 1);
      if (k == 11) check("not_halted_e11", halted, 0);
    end
    check("we_pattern", wv, 16'h0248);
    check("main_halted", halted, 1);
    check("main_count", cnt, 3);
    check("main_pc", pc, 12);
    check("main_err", err, 0);
    check("main_busy_halted", busy, 0);

    // Illegal word at PC 4.
    rom[1] = 32'hFFFF_FFFF;
    pulse_start();
    check("restart_fetch_addr", {bus.imem_en_o, 6'd0, bus.imem_addr_o}, {1'b1, 6'd0, 10'd0});
    run_to_halt(50, writes, ok);
    check("illegal_halt_reached", ok, 1);
    check("illegal_err", err, 1);
    check("illegal_count", cnt, 1);
    check("illegal_writes", writes, 1);
    check("illegal_pc", pc, 4);
    pulse_start();
    check("restart_clears_err", err, 0);
    run_to_halt(50, writes, ok);
    check("illegal_halt_again", ok, 1);

    // Single-instruction vector table: instr then halt word.
    vecs[0]  = '{32'h0010_8093, 1, 16'd1, 1'b0, 10'd4};
    vecs[1]  = '{32'h0000_0013, 0, 16'd1, 1'b0, 10'd4};
    vecs[2]  = '{32'h0000_10B7, 1, 16'd1, 1'b0, 10'd4};
    vecs[3]  = '{32'h0000_1037, 0, 16'd1, 1'b0, 10'd4};
    vecs[4]  = '{32'h0000_1097, 1, 16'd1, 1'b0, 10'd4};
    vecs[5]  = '{32'h0010_8133, 1, 16'd1, 1'b0, 10'd4};
    vecs[6]  = '{32'h0011_2023, 0, 16'd1, 1'b0, 10'd4};
    vecs[7]  = '{32'h0020_8063, 0, 16'd1, 1'b0, 10'd4};
    vecs[8]  = '{32'h0000_0000, 0, 16'd0, 1'b1, 10'd0};
    vecs[9]  = '{32'hFFFF_FFFF, 0, 16'd0, 1'b1, 10'd0};
    vecs[10] = '{32'h0000_2083, 0, 16'd0, 1'b1, 10'd0};
    vecs[11] = '{32'h0000_006F, 0, 16'd0, 1'b1, 10'd0};
    vecs[12] = '{32'h0000_0073, 0, 16'd0, 1'b0, 10'd0};
    vecs[13] = '{32'h0010_0073, 0, 16'd0, 1'b1, 10'd0};
    for (int v = 0; v < 14; v++) begin
      rom[0] = vecs[v].instr;
      rom[1] = HALT;
      pulse_start();
      run_to_halt(50, writes, ok);
      check($sformatf("v%0d_halt", v), ok, 1);
      check($sformatf("v%0d_writes", v), writes, vecs[v].writes);
      check($sformatf("v%0d_count", v), cnt, vecs[v].count);
      check($sformatf("v%0d_err", v), err, vecs[v].error);
      check($sformatf("v%0d_pc", v), pc, vecs[v].pc);
    end

    // Step mode.
    load_main_rom();
    step_mode = 1'b1;
    pulse_start();
    tick();
    tick();
    check("step_first_we", we, 1);
    hold = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy && !we && !bus.imem_en_o && !halted) hold++;
    end
    check("pause_hold20", hold, 20);
    check("pause_count", cnt, 1);
    wv = '0;
    step = 1'b1;
    tick();
    step = 1'b0;
    wv[0] = we;
    for (int k = 1; k <= 3; k++) begin
      tick();
      wv[k] = we;
    end
    check("step1_we_pattern", wv, 16'h0004);
    // Second step: step_i is also high in the ISSUE cycle and must be ignored.
    wv = '0;
    step = 1'b1;
    tick();
    step = 1'b0;
    wv[0] = we;
    tick(); wv[1] = we;
    tick(); wv[2] = we;
    step = 1'b1;
    tick(); wv[3] = we;
    step = 1'b0;
    tick(); wv[4] = we;
    tick(); wv[5] = we;
    check("step2_we_pattern", wv, 16'h0004);
    check("step2_still_paused", {busy, bus.imem_en_o}, 2'b10);
    check("step2_count", cnt, 3);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    check("step3_halted", halted, 1);
    check("step3_count", cnt, 3);

    // Dropping step_mode in PAUSE resumes without step_i.
    pulse_start();
    tick(); tick(); tick();
    step_mode = 1'b0;
    tick();
    check("mode_drop_fetch", bus.imem_en_o, 1);
    run_to_halt(50, writes, ok);
    check("mode_drop_writes", writes, 2);

    // Abort during LOAD of the third instruction.
    pulse_start();
    for (int k = 2; k <= 8; k++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_we", we, 0);
    check("abort_idle", {busy, halted}, 2'b00);
    check("abort_pc_kept", pc, 8);
    check("abort_count_kept", cnt, 2);
    check("abort_instr_kept", instruction, 32'h0010_8133);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_beats_start", busy, 0);
    pulse_start();
    check("refetch_reset_pc", {bus.imem_en_o, 6'd0, bus.imem_addr_o}, {1'b1, 6'd0, 10'd0});
    check("refetch_count_cleared", cnt, 0);
    run_to_halt(50, writes, ok);
    check("refetch_count", cnt, 3);

    // Asynchronous reset in the middle of an ISSUE cycle.
    pulse_start();
    tick();
    tick();
    check("pre_reset_we", we, 1);
    #2 rst = 1'b1;
    #1;
    check("areset_we", we, 0);
    check("areset_flags", {bus.imem_en_o, busy, halted, err}, 0);
    check("areset_pc", pc, 0);
    check("areset_count", cnt, 0);
    check("areset_instr", instruction, 0);
    #3 rst = 1'b0;
    tick();
    check("post_reset_idle", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
